// File: rtl/cosim_endpoint.sv
// cosim_endpoint: bridges one valid/ready message pair to host byte-stream frames (kind, 4-byte ID, payload LSB first)
//   clk, rstn                                   : rising-edge clock, async active-low reset
//   DataOutValid/DataOutReady/DataOut           : message decoded from HostRx frames
//   DataInValid/DataInReady/DataIn              : message encoded into HostTx frames
//   HostRxValid/HostRxReady/HostRxData          : byte stream from host
//   HostTxValid/HostTxReady/HostTxData          : byte stream to host
//   COSIM_ENDPOINT_REGISTER_EN                  : emit a registration frame (0x01, ID, ESI_TYPE_ID) after each reset release
module cosim_endpoint #(
  parameter logic [31:0] ENDPOINT_ID    = 0,
  parameter logic [63:0] ESI_TYPE_ID    = 0,
  parameter int          TYPE_SIZE_BITS = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  output logic                      DataOutValid,
  input  logic                      DataOutReady,
  output logic [TYPE_SIZE_BITS-1:0] DataOut,
  input  logic                      DataInValid,
  output logic                      DataInReady,
  input  logic [TYPE_SIZE_BITS-1:0] DataIn,
  input  logic                      HostRxValid,
  output logic                      HostRxReady,
  input  logic [7:0]                HostRxData,
  output logic                      HostTxValid,
  input  logic                      HostTxReady,
  output logic [7:0]                HostTxData
);
  localparam int NBYTES = (TYPE_SIZE_BITS + 7) / 8;
  localparam int PW = 8 * NBYTES;
  // one shift register serves both the data frame (ID+payload) and the registration frame (ID+type)
  localparam int SW = (PW > $bits(ESI_TYPE_ID)) ? PW + 32 : $bits(ESI_TYPE_ID) + 32;
  localparam int CW = $clog2(13 + NBYTES);
  localparam logic [CW-1:0] DATA_LAST = CW'(4 + NBYTES);
  localparam logic [CW-1:0] REG_LAST = CW'(12);
  localparam logic [CW-1:0] PAY_FIRST = CW'(5);
  typedef enum logic [1:0] {TX_START, TX_IDLE, TX_DATA, TX_REG} tx_state_t;
  tx_state_t         r_tx_st;
  logic [CW-1:0]     r_tx_cnt;
  logic [SW-1:0]     r_tx_sh;
  logic [PW-1:0]     w_tx_pay;
  logic              w_tx_last;
  logic              r_rx_en;
  logic              r_rx_bad;
  logic [CW-1:0]     r_rx_cnt;
  logic [PW-1:0]     r_rx_sh;
  logic              w_rx_hs;
  logic              w_rx_mis;
  logic [31:0]       w_id;
  logic [1:0]        w_id_sel;
  logic [7:0]        w_id_byte;
  assign w_tx_pay  = PW'(DataIn);
  assign w_tx_last = (r_tx_st == TX_REG) ? (r_tx_cnt == REG_LAST) : (r_tx_cnt == DATA_LAST);
  // HostTxData is the byte at index r_tx_cnt; the next byte is always the bottom of the shift register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx_st     <= TX_START;
      r_tx_cnt    <= '0;
      r_tx_sh     <= '0;
      HostTxValid <= 1'b0;
      HostTxData  <= '0;
      DataInReady <= 1'b0;
    end else begin
      case (r_tx_st)
        TX_START: begin
`ifdef COSIM_ENDPOINT_REGISTER_EN
          r_tx_st     <= TX_REG;
          r_tx_cnt    <= '0;
          r_tx_sh     <= SW'({ESI_TYPE_ID, ENDPOINT_ID});
          HostTxValid <= 1'b1;
          HostTxData  <= 8'h01;
`else
          r_tx_st     <= TX_IDLE;
          DataInReady <= 1'b1;
`endif
        end
        TX_IDLE: if (DataInValid) begin
          r_tx_st     <= TX_DATA;
          r_tx_cnt    <= '0;
          r_tx_sh     <= SW'({w_tx_pay, ENDPOINT_ID});
          HostTxValid <= 1'b1;
          HostTxData  <= 8'h00;
          DataInReady <= 1'b0;
        end
        default: if (HostTxReady) begin
          if (w_tx_last) begin
            r_tx_st     <= TX_IDLE;
            HostTxValid <= 1'b0;
            HostTxData  <= '0;
            DataInReady <= 1'b1;
          end else begin
            r_tx_cnt   <= r_tx_cnt + 1'b1;
            HostTxData <= r_tx_sh[7:0];
            r_tx_sh    <= r_tx_sh >> 8;
          end
        end
      endcase
    end
  end
  assign w_rx_hs   = HostRxValid & HostRxReady;
  assign w_id      = ENDPOINT_ID;
  // counts 1..4 address ID bytes 0..3
  assign w_id_sel  = r_rx_cnt[1:0] - 2'd1;
  assign w_id_byte = w_id[{w_id_sel, 3'b000} +: 8];
  assign w_rx_mis  = (r_rx_cnt == '0) ? (HostRxData != 8'h00) :
                     (r_rx_cnt < PAY_FIRST) ? (HostRxData != w_id_byte) : 1'b0;
  assign HostRxReady = r_rx_en & ~DataOutValid;
  // payload bytes shift in from the top; the last byte is merged straight into DataOut
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_en      <= 1'b0;
      r_rx_bad     <= 1'b0;
      r_rx_cnt     <= '0;
      r_rx_sh      <= '0;
      DataOut      <= '0;
      DataOutValid <= 1'b0;
    end else begin
      r_rx_en <= 1'b1;
      if (DataOutValid && DataOutReady) DataOutValid <= 1'b0;
      if (w_rx_hs) begin
        if (r_rx_cnt == DATA_LAST) begin
          r_rx_cnt <= '0;
          r_rx_bad <= 1'b0;
          if (!r_rx_bad) begin
            DataOut      <= TYPE_SIZE_BITS'({HostRxData, r_rx_sh} >> 8);
            DataOutValid <= 1'b1;
          end
        end else begin
          r_rx_cnt <= r_rx_cnt + 1'b1;
          r_rx_bad <= r_rx_bad | w_rx_mis;
          if (r_rx_cnt >= PAY_FIRST && !r_rx_bad) r_rx_sh <= PW'({HostRxData, r_rx_sh} >> 8);
        end
      end
    end
  end
endmodule

// File: tb/tb_cosim_endpoint.sv
// tb_cosim_endpoint: randomized frame-level check of cosim_endpoint against a byte-queue frame model
module tb_cosim_endpoint;
  localparam int W = 1026;
  localparam int N = (W + 7) / 8;
  localparam int NW = (8 * N + 31) / 32;
  localparam logic [31:0] ID = 32'd1;
  localparam logic [63:0] ESI = 64'd1;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, rstn = 1'b0;
  logic DataOutValid, DataOutReady, DataInValid, DataInReady;
  logic [W-1:0] DataOut, DataIn;
  logic HostRxValid, HostRxReady, HostTxValid, HostTxReady;
  logic [7:0] HostRxData, HostTxData;
  int n_tests = 0, n_fail = 0;
  cosim_endpoint #(.ENDPOINT_ID(ID), .ESI_TYPE_ID(ESI), .TYPE_SIZE_BITS(W)) dut (
    .clk(clk), .rstn(rstn),
    .DataOutValid(DataOutValid), .DataOutReady(DataOutReady), .DataOut(DataOut),
    .DataInValid(DataInValid), .DataInReady(DataInReady), .DataIn(DataIn),
    .HostRxValid(HostRxValid), .HostRxReady(HostRxReady), .HostRxData(HostRxData),
    .HostTxValid(HostTxValid), .HostTxReady(HostTxReady), .HostTxData(HostTxData));
  always #5 clk = ~clk;
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [1031:0] obs, input logic [1031:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic bq_t mkframe(input logic [7:0] kind, input logic [31:0] id, input logic [8*N-1:0] pay);
    bq_t q;
    q.push_back(kind);
    for (int i = 0; i < 4; i++) q.push_back(id[8*i +: 8]);
    for (int i = 0; i < N; i++) q.push_back(pay[8*i +: 8]);
    return q;
  endfunction
  function automatic logic [8*N-1:0] rnd_pay();
    logic [32*NW-1:0] v;
    for (int i = 0; i < NW; i++) v[32*i +: 32] = $urandom;
    return v[8*N-1:0];
  endfunction
  task automatic chk_frame(input string tag, input bq_t got, input bq_t exp);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), got[i], exp[i]);
  endtask
  // mode 0: ready always, 1: ready every other cycle, 2: random ready
  task automatic collect(input int n, input int mode, output bq_t got);
    int t = 0;
    logic stalled = 1'b0;
    logic [7:0] prev = 8'h00;
    got = {};
    while (got.size() < n && t < 4000) begin
      if (stalled) chk("tx_hold_stable", HostTxData, prev);
      HostTxReady = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((t % 2) == 0) : 1'($urandom_range(0, 1));
      stalled = HostTxValid && !HostTxReady;
      prev = HostTxData;
      if (HostTxValid && HostTxReady) got.push_back(HostTxData);
      @(negedge clk);
      t++;
    end
    HostTxReady = 1'b0;
  endtask
  task automatic do_tx(input logic [W-1:0] d, input int mode);
    bq_t got;
    int t = 0;
    DataIn = d;
    DataInValid = 1'b1;
    while (!DataInReady && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("tx_accept", DataInReady, 1);
    @(negedge clk);
    DataInValid = 1'b0;
    chk("tx_first_valid", HostTxValid, 1);
    chk("tx_first_byte", HostTxData, 0);
    chk("tx_busy", DataInReady, 0);
    collect(5 + N, mode, got);
    chk("tx_ready_after", DataInReady, 1);
    chk("tx_valid_after", HostTxValid, 0);
    chk_frame("tx", got, mkframe(8'h00, ID, (8*N)'(d)));
  endtask
  task automatic do_rx(input bq_t fb, input int gaps, output int consumed);
    int t = 0;
    consumed = 0;
    for (int i = 0; i < fb.size(); i++) begin
      if (gaps != 0 && $urandom_range(0, 2) == 0) begin
        HostRxValid = 1'b0;
        @(negedge clk);
      end
      HostRxValid = 1'b1;
      HostRxData = fb[i];
      while (!HostRxReady && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (HostRxReady) consumed++;
      @(negedge clk);
    end
    HostRxValid = 1'b0;
    HostRxData = 8'h00;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_dov"}, DataOutValid, 0);
    chk({tag, "_do"}, DataOut, 0);
    chk({tag, "_htv"}, HostTxValid, 0);
    chk({tag, "_htd"}, HostTxData, 0);
    chk({tag, "_dir"}, DataInReady, 0);
    chk({tag, "_hrr"}, HostRxReady, 0);
  endtask
  task automatic post_release();
    bq_t got, exp;
    @(negedge clk);
    chk("rel_hrr", HostRxReady, 1);
`ifdef COSIM_ENDPOINT_REGISTER_EN
    chk("rel_dir_reg", DataInReady, 0);
    exp = {8'h01};
    for (int i = 0; i < 4; i++) exp.push_back(ID[8*i +: 8]);
    for (int i = 0; i < 8; i++) exp.push_back(ESI[8*i +: 8]);
    collect(13, 0, got);
    chk_frame("reg", got, exp);
    chk("reg_dir_after", DataInReady, 1);
`else
    chk("rel_dir", DataInReady, 1);
    chk("rel_htv", HostTxValid, 0);
`endif
  endtask
  task automatic rx_good(input string tag, input logic [8*N-1:0] p, input int gaps);
    int c;
    do_rx(mkframe(8'h00, ID, p), gaps, c);
    chk({tag, "_consumed"}, c, 5 + N);
    chk({tag, "_valid"}, DataOutValid, 1);
    chk({tag, "_data"}, DataOut, p[W-1:0]);
    chk({tag, "_hrr"}, HostRxReady, 0);
  endtask
  task automatic ack(input string tag);
    DataOutReady = 1'b1;
    @(negedge clk);
    chk({tag, "_ack_valid"}, DataOutValid, 0);
    chk({tag, "_ack_hrr"}, HostRxReady, 1);
    DataOutReady = 1'b0;
  endtask
  initial begin
    logic [8*N-1:0] p;
    logic [W-1:0] held;
    bq_t fb;
    int c;
    DataOutReady = 0; DataInValid = 0; DataIn = '0;
    HostRxValid = 0; HostRxData = 0; HostTxReady = 0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rstn = 1'b1;
    post_release();
    do_tx('1, 0);
    do_tx('1, 1);
    repeat (3) do_tx(W'(rnd_pay()), 2);
    p = {N{8'hAA}};
    rx_good("rx_aa", p, 0);
    held = DataOut;
    HostRxValid = 1'b1;
    HostRxData = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_hrr", HostRxReady, 0);
      chk("hold_data", DataOut, held);
      chk("hold_valid", DataOutValid, 1);
    end
    HostRxValid = 1'b0;
    ack("rx_aa");
    do_rx(mkframe(8'h00, 32'd2, rnd_pay()), 1, c);
    chk("badid_consumed", c, 5 + N);
    chk("badid_valid", DataOutValid, 0);
    chk("badid_data", DataOut, held);
    do_rx(mkframe(8'h05, ID, rnd_pay()), 0, c);
    chk("badkind_consumed", c, 5 + N);
    chk("badkind_valid", DataOutValid, 0);
    chk("badkind_data", DataOut, held);
    rx_good("rx_rnd", rnd_pay(), 1);
    ack("rx_rnd");
    p = rnd_pay();
    fork
      do_tx(W'(rnd_pay()), 2);
      do_rx(mkframe(8'h00, ID, p), 1, c);
    join
    chk("par_consumed", c, 5 + N);
    chk("par_valid", DataOutValid, 1);
    chk("par_data", DataOut, p[W-1:0]);
    ack("par");
    fb = mkframe(8'h00, ID, rnd_pay());
    do_rx(fb[0:6], 0, c);
    DataIn = W'(rnd_pay());
    DataInValid = 1'b1;
    HostTxReady = 1'b1;
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    DataInValid = 1'b0;
    HostTxReady = 1'b0;
    #1;
    chk_reset("mid");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    post_release();
    rx_good("rx_after_rst", rnd_pay(), 0);
    ack("rx_after_rst");
    do_tx(W'(rnd_pay()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
